// File: rtl/core_csr_access_unit.sv
// Zicsr sequencer toward core_csr_file: accept, check legality, read, modify, write back, respond.
// Legal op: response 3 cycles after accept, static-illegal 2; one op in flight, response held until resp_ready.
module core_csr_access_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [2:0]      i_req_funct3,
    input  logic [11:0]     i_req_csr_sel,
    input  logic [XLEN-1:0] i_req_rs1_val,
    input  logic [4:0]      i_req_rs1_idx,
    input  logic            i_req_rd_zero,
    input  logic [1:0]      i_priv,
    input  logic            i_flush,
    output logic [11:0]     o_csr_sel,
    output logic            o_csr_rd_en,
    input  logic [XLEN-1:0] i_csr_data_in,
    input  logic            i_csr_illegal,
    output logic            o_csr_wr_en,
    output logic [XLEN-1:0] o_csr_wr_data,
    output logic            o_resp_valid,
    input  logic            i_resp_ready,
    output logic [XLEN-1:0] o_resp_rd_data,
    output logic            o_resp_illegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_WB   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [2:0]        r_funct3;
    logic [11:0]       r_csr_sel;
    logic [XLEN-1:0]   r_rs1_val;
    logic [4:0]        r_rs1_idx;
    logic              r_rd_zero;
    logic [1:0]        r_priv;
    logic [XLEN-1:0]   r_rd_data;
    logic              r_resp_illegal;

    logic              w_accept;
    logic              w_is_rw;
    logic              w_op_ok;
    logic [XLEN-1:0]   w_src;
    logic              w_do_wr;
    logic              w_do_rd;
    logic              w_static_ill;
    logic [XLEN-1:0]   w_new;

    assign w_accept = i_req_valid && (r_state == S_IDLE) && !i_flush;

    assign w_is_rw      = (r_funct3[1:0] == 2'b01);
    assign w_op_ok      = (r_funct3[1:0] != 2'b00);
    assign w_src        = r_funct3[2] ? {{(XLEN-5){1'b0}}, r_rs1_idx} : r_rs1_val;
    assign w_do_wr      = w_is_rw || (r_rs1_idx != 5'd0);
    assign w_do_rd      = !(w_is_rw && r_rd_zero);
    // Encoded privilege in csr_sel[9:8] is the minimum level; [11:10]==11 marks read-only space.
    assign w_static_ill = !w_op_ok || (r_priv < r_csr_sel[9:8]) ||
                          (w_do_wr && (r_csr_sel[11:10] == 2'b11));

    always_comb begin
        w_new = w_src;
        case (r_funct3[1:0])
            2'b10:   w_new = i_csr_data_in | w_src;
            2'b11:   w_new = i_csr_data_in & ~w_src;
            default: w_new = w_src;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (i_flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) w_next = S_ACC;
                S_ACC:   w_next = w_static_ill ? S_RESP : S_WB;
                S_WB:    w_next = S_RESP;
                S_RESP:  if (i_resp_ready) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_req_ready    = (r_state == S_IDLE) && !i_flush;
        o_csr_sel      = r_csr_sel;
        o_csr_rd_en    = (r_state == S_ACC) && w_do_rd && !w_static_ill && !i_flush;
        o_csr_wr_en    = (r_state == S_WB) && w_do_wr && !i_csr_illegal && !i_flush;
        o_csr_wr_data  = (r_state == S_WB) ? w_new : '0;
        o_resp_valid   = (r_state == S_RESP);
        o_resp_rd_data = r_rd_data;
        o_resp_illegal = r_resp_illegal;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_funct3       <= '0;
            r_csr_sel      <= '0;
            r_rs1_val      <= '0;
            r_rs1_idx      <= '0;
            r_rd_zero      <= 1'b0;
            r_priv         <= '0;
            r_rd_data      <= '0;
            r_resp_illegal <= 1'b0;
        end else if (w_accept) begin
            r_funct3       <= i_req_funct3;
            r_csr_sel      <= i_req_csr_sel;
            r_rs1_val      <= i_req_rs1_val;
            r_rs1_idx      <= i_req_rs1_idx;
            r_rd_zero      <= i_req_rd_zero;
            r_priv         <= i_priv;
            r_rd_data      <= '0;
            r_resp_illegal <= 1'b0;
        end else if (!i_flush) begin
            if ((r_state == S_ACC) && w_static_ill) begin
                r_resp_illegal <= 1'b1;
            end else if (r_state == S_WB) begin
                r_rd_data      <= i_csr_illegal ? '0 : i_csr_data_in;
                r_resp_illegal <= i_csr_illegal;
            end
        end
    end

endmodule

// File: tb/tb_core_csr_access_unit.sv
// Directed bench for core_csr_access_unit with a CSR-file responder and an op-level expectation model.
module tb_core_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_funct3 = '0;
    logic [11:0] req_csr_sel = '0;
    logic [31:0] req_rs1_val = '0;
    logic [4:0]  req_rs1_idx = '0;
    logic        req_rd_zero = 1'b0;
    logic [1:0]  priv = 2'd3;
    logic        flush = 1'b0;
    logic [11:0] csr_sel;
    logic        csr_rd_en;
    logic [31:0] csr_data_in;
    logic        csr_illegal;
    logic        csr_wr_en;
    logic [31:0] csr_wr_data;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rd_data;
    logic        resp_illegal;

    core_csr_access_unit #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_funct3(req_funct3), .i_req_csr_sel(req_csr_sel),
        .i_req_rs1_val(req_rs1_val), .i_req_rs1_idx(req_rs1_idx),
        .i_req_rd_zero(req_rd_zero), .i_priv(priv), .i_flush(flush),
        .o_csr_sel(csr_sel), .o_csr_rd_en(csr_rd_en),
        .i_csr_data_in(csr_data_in), .i_csr_illegal(csr_illegal),
        .o_csr_wr_en(csr_wr_en), .o_csr_wr_data(csr_wr_data),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
        .o_resp_rd_data(resp_rd_data), .o_resp_illegal(resp_illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // CSR file stand-in: data and illegal flag appear the cycle after the address is presented.
    logic [31:0] mem  [0:4095];
    logic        impl [0:4095];
    logic        tb_init = 1'b1;

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 4096; i++) begin
                mem[i]  <= 32'd0;
                impl[i] <= 1'b0;
            end
            mem[12'h340] <= 32'h12345678; impl[12'h340] <= 1'b1;
            mem[12'h300] <= 32'h00001800; impl[12'h300] <= 1'b1;
            mem[12'h341] <= 32'hFFFFFFFF; impl[12'h341] <= 1'b1;
            mem[12'hF14] <= 32'h00000000; impl[12'hF14] <= 1'b1;
        end else if (csr_wr_en) begin
            mem[csr_sel] <= csr_wr_data;
        end
        csr_data_in <= mem[csr_sel];
        csr_illegal <= !impl[csr_sel];
    end

    typedef struct {
        logic        ill;
        logic [31:0] rd;
        int          wr;
        logic [31:0] wdata;
        int          rd_pulse;
        int          lat;
    } exp_t;

    // Outcome of one Zicsr op computed from the instruction rules and the current CSR contents.
    function automatic exp_t model(input logic [2:0] f3, input logic [11:0] sel,
                                   input logic [31:0] rs1, input logic [4:0] idx,
                                   input logic rdz, input logic [1:0] pv);
        exp_t        e;
        logic [31:0] src;
        logic [31:0] old;
        int          kind;  // 1 write, 2 set, 3 clear, 0 bad
        bit          writes;
        bit          bad;
        kind   = int'(f3 & 3'b011);
        src    = f3[2] ? {27'd0, idx} : rs1;
        old    = mem[sel];
        writes = (kind == 1) || (idx != 5'd0);
        bad    = (kind == 0) || (pv < sel[9:8]) || (writes && sel[11:10] == 2'b11);
        if (bad) begin
            e.ill = 1'b1; e.rd = 32'd0; e.wr = 0; e.wdata = 32'd0; e.rd_pulse = 0; e.lat = 2;
        end else begin
            e.lat      = 3;
            e.rd_pulse = (kind == 1 && rdz) ? 0 : 1;
            e.ill      = !impl[sel];
            e.rd       = e.ill ? 32'd0 : old;
            e.wr       = (writes && !e.ill) ? 1 : 0;
            if (kind == 1)      e.wdata = src;
            else if (kind == 2) e.wdata = old | src;
            else                e.wdata = old & ~src;
        end
        return e;
    endfunction

    exp_t        exp_e;
    logic [11:0] exp_sel;
    bit          in_op = 1'b0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;

    always @(negedge clk) begin
        if (in_op) begin
            check("rd_wr_exclusive", {31'd0, csr_rd_en & csr_wr_en}, 32'd0);
            if (csr_rd_en) begin
                rd_cnt++;
                check("rd_sel", {20'd0, csr_sel}, {20'd0, exp_sel});
            end
            if (csr_wr_en) begin
                wr_cnt++;
                check("wr_sel", {20'd0, csr_sel}, {20'd0, exp_sel});
                check("wr_data", csr_wr_data, exp_e.wdata);
            end
            if (resp_valid) begin
                check("resp_rd_data", resp_rd_data, exp_e.rd);
                check("resp_illegal", {31'd0, resp_illegal}, {31'd0, exp_e.ill});
                check("resp_req_ready_low", {31'd0, req_ready}, 32'd0);
                check("resp_sel_held", {20'd0, csr_sel}, {20'd0, exp_sel});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the response handshake edge.
    task automatic run_op(input logic [2:0] f3, input logic [11:0] sel, input logic [31:0] rs1,
                          input logic [4:0] idx, input logic rdz, input logic [1:0] pv,
                          input int hold, input logic [31:0] lit_rd, input logic lit_ill);
        int cyc;
        exp_e   = model(f3, sel, rs1, idx, rdz, pv);
        exp_sel = sel;
        rd_cnt  = 0;
        wr_cnt  = 0;
        req_valid = 1'b1; req_funct3 = f3; req_csr_sel = sel; req_rs1_val = rs1;
        req_rs1_idx = idx; req_rd_zero = rdz; priv = pv;
        @(negedge clk);
        check("accept_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        in_op = 1'b1;
        cyc = 1;
        while (cyc < 20) begin
            @(negedge clk);
            if (resp_valid) break;
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, exp_e.lat);
        check("rd_pulses", rd_cnt, exp_e.rd_pulse);
        check("wr_pulses", wr_cnt, exp_e.wr);
        check("lit_rd", resp_rd_data, lit_rd);
        check("lit_ill", {31'd0, resp_illegal}, {31'd0, lit_ill});
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        in_op = 1'b0;
    endtask

    task automatic flush_op(input int at);
        req_valid = 1'b1; req_funct3 = 3'b001; req_csr_sel = 12'h340; req_rs1_val = 32'h11111111;
        req_rs1_idx = 5'd1; req_rd_zero = 1'b0; priv = 2'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (at == 2) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush_rd_en", {31'd0, csr_rd_en}, 32'd0);
        check("flush_wr_en", {31'd0, csr_wr_en}, 32'd0);
        check("flush_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_idle_ready", {31'd0, req_ready}, 32'd1);
        check("flush_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("flush_no_write", mem[12'h340], 32'h00000015);
        @(posedge clk); #1;
    endtask

    initial begin
        #3;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_csr_sel", {20'd0, csr_sel}, 32'd0);
        check("rst_rd_en", {31'd0, csr_rd_en}, 32'd0);
        check("rst_wr_en", {31'd0, csr_wr_en}, 32'd0);
        check("rst_wr_data", csr_wr_data, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rd_data", resp_rd_data, 32'd0);
        check("rst_resp_illegal", {31'd0, resp_illegal}, 32'd0);
        repeat (2) @(posedge clk);
        #1 tb_init = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(3'b001, 12'h340, 32'hDEADBEEF, 5'd1, 1'b0, 2'd3, 0, 32'h12345678, 1'b0);
        check("mscratch_written", mem[12'h340], 32'hDEADBEEF);
        run_op(3'b010, 12'h300, 32'hFFFFFFFF, 5'd0, 1'b0, 2'd3, 0, 32'h00001800, 1'b0);
        check("mstatus_unchanged", mem[12'h300], 32'h00001800);
        run_op(3'b111, 12'h341, 32'h0, 5'h1F, 1'b0, 2'd3, 0, 32'hFFFFFFFF, 1'b0);
        check("rcci_result", mem[12'h341], 32'hFFFFFFE0);
        run_op(3'b001, 12'h340, 32'h0000CAFE, 5'd2, 1'b1, 2'd3, 0, 32'hDEADBEEF, 1'b0);
        check("rw_x0_written", mem[12'h340], 32'h0000CAFE);
        run_op(3'b010, 12'hF14, 32'h0, 5'd0, 1'b0, 2'd3, 0, 32'h0, 1'b0);
        run_op(3'b010, 12'hF14, 32'h0, 5'd3, 1'b0, 2'd3, 0, 32'h0, 1'b1);
        run_op(3'b010, 12'h300, 32'h0, 5'd0, 1'b0, 2'd0, 0, 32'h0, 1'b1);
        run_op(3'b001, 12'h7C0, 32'h1, 5'd1, 1'b0, 2'd3, 0, 32'h0, 1'b1);
        run_op(3'b000, 12'h340, 32'h1, 5'd1, 1'b0, 2'd3, 0, 32'h0, 1'b1);
        run_op(3'b110, 12'h300, 32'h0, 5'd6, 1'b0, 2'd3, 0, 32'h00001800, 1'b0);
        check("rsi_result", mem[12'h300], 32'h00001806);
        run_op(3'b010, 12'h300, 32'h0, 5'd0, 1'b0, 2'd3, 5, 32'h00001806, 1'b0);
        run_op(3'b101, 12'h340, 32'h0, 5'h15, 1'b0, 2'd3, 0, 32'h0000CAFE, 1'b0);
        check("rwi_result", mem[12'h340], 32'h00000015);

        flush_op(1);
        flush_op(2);

        req_valid = 1'b1; req_funct3 = 3'b001; req_csr_sel = 12'h340; req_rs1_idx = 5'd1; flush = 1'b1;
        @(negedge clk);
        check("flush_idle_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_idle_no_accept", {31'd0, csr_rd_en}, 32'd0);
        @(posedge clk); #1;

        req_valid = 1'b1; req_funct3 = 3'b001; req_csr_sel = 12'h340; req_rs1_val = 32'h22222222;
        req_rs1_idx = 5'd1; req_rd_zero = 1'b0; priv = 2'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        #2;
        check("pre_rst_wr_en", {31'd0, csr_wr_en}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_wr_en", {31'd0, csr_wr_en}, 32'd0);
        check("rst_async_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_no_write", mem[12'h340], 32'h00000015);
        @(posedge clk); #1;

        run_op(3'b011, 12'h300, 32'h00000006, 5'd4, 1'b0, 2'd3, 0, 32'h00001806, 1'b0);
        check("rc_result", mem[12'h300], 32'h00001800);
        check("mepc_final", mem[12'h341], 32'hFFFFFFE0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
